peripheral_muldiv: RTL and testbench
====================================

Name: peripheral_muldiv

Overview:
Memory-mapped arithmetic peripheral on the 16-bit processor bus. Performs unsigned WIDTH-bit multiplication (shift-add) or division (restoring) with one iteration per clock. Extends the fixed multiplier peripheral with:
- parametrised operand width
- divide mode with divide-by-zero flag
- busy/done status
- optional level interrupt
- 2-word result readback

Parameters:
WIDTH, 16, operand width in bits; legal range 4..16.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
d_in  in  16  bus write data
cs  in  1  chip select; rd/wr ignored when low
addr  in  3  register address
rd  in  1  read strobe
wr  in  1  write strobe
d_out  out  16  registered read data
irq  out  1  interrupt, level, = done & irq_en

Behaviour:
- Reset: all registers, d_out, irq, and state go to 0/IDLE immediately and asynchronously. Reset mid-operation aborts the operation; no result is written.
- Register map:
  - 0 A: R/W; stores d_in[WIDTH-1:0]; reads zero-extended.
  - 1 B: R/W; same format as A.
  - 2 CTRL/STATUS:
    - Write: bit0 start, bit1 mode (0 mul, 1 div), bit2 irq_en, bit3 clr_done (clears done and div0).
    - Read: {11'b0, irq_en, mode, div0, busy, done}.
  - 3 RES_LO: R only. Mul: product[15:0]. Div: quotient zero-extended.
  - 4 RES_HI: R only. Mul: product[31:16] (product zero-extended to 32 bits). Div: remainder zero-extended.
  - 5..7: read 0, writes ignored.
- Reads: when cs&rd at an edge, d_out <= selected register (pre-edge value); otherwise d_out <= 0. Read latency is 1 cycle.
- Simultaneous cs&rd&wr to the same address: the write lands, and the read returns the old value.
- FSM states: IDLE, MUL, DIV.
- Start accept edge E0 (cs&wr, addr 2, d_in[0]=1, state IDLE):
  - mode and irq_en are latched; done and div0 are cleared.
  - Working registers load A and B; counter loads WIDTH.
  - State goes to MUL or DIV; busy = 1.
- Iteration: each following edge performs one iteration and decrements the counter. On the edge where the counter reaches 0:
  - RES_LO/RES_HI are written.
  - done = 1, busy = 0, state returns to IDLE.
  - done therefore appears after edge E0+WIDTH, and busy is high for exactly WIDTH cycles.
- Result registers hold the previous result until a completion writes new values.
- Divide by zero (mode 1, B == 0 at E0):
  - State stays IDLE and no iterations run.
  - At E0+1: quotient = all ones (WIDTH bits), remainder = A, div0 = 1, done = 1.
- While busy:
  - Writes to A, B, and CTRL are ignored entirely, including start, clr_done, and irq_en.
  - Reads proceed normally.
- A CTRL write with start=0 updates mode and irq_en, and applies clr_done if set.
- A start write with clr_done=1 is treated as start; done is cleared in either case.
- done is sticky until the next start, clr_done, or reset.
- irq follows done & irq_en combinationally from registers; no extra latency.

Test Plan:
1. WIDTH=16. Write A=5, B=2, CTRL=0x0001. Poll status.
   -> busy=1 for 16 cycles, then done=1. RES_LO=0x000A, RES_HI=0x0000.
2. Write A=0xFFFF, B=0xFFFF, start mul.
   -> RES_LO=0x0001, RES_HI=0xFFFE, done after 16 cycles.
3. Write A=100, B=7, CTRL=0x0003 (div).
   -> RES_LO=14, RES_HI=2, div0=0.
   Then A=35, B=0, div start -> one cycle later done=1, div0=1, RES_LO=0xFFFF, RES_HI=35.
4. Start mul 5*2. While busy, write A=9 and issue start again.
   -> A still reads 5; result 0x000A; done exactly 16 cycles after the first start.
5. Write CTRL=0x0005 (irq_en, mul start) with 3*4.
   -> irq rises with done, RES_LO=12.
   Write CTRL=0x0004|0x8 (clr_done) -> irq and done drop the next cycle.
6. Start a div, assert rst at iteration 5.
   -> all status, results, d_out, and irq are 0 immediately.
   Deassert rst, then run 5*2 -> correct result of 10.

Source files
------------

// File: rtl/peripheral_muldiv.sv
// Memory-mapped unsigned multiply/divide unit on the 16-bit bus.
// Ports: clk, rst, d_in/cs/addr/rd/wr bus in; d_out read data; irq level.
module peripheral_muldiv #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [2:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               mode_q;
  logic               irq_en_q;
  logic               done_q;
  logic               div0_q;
  logic               pend_q;
  logic [15:0]        res_lo_q;
  logic [15:0]        res_hi_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvsr_q;

  logic               busy;
  logic               wr_en;
  logic               ctrl_wr;
  logic               start;
  logic               last;
  logic [15:0]        rd_data;

  logic [2*WIDTH-1:0] mul_sum;
  logic [31:0]        prod;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  assign busy    = (state_q != IDLE);
  assign wr_en   = cs & wr & ~busy;
  assign ctrl_wr = wr_en & (addr == 3'd2);
  // A pending divide-by-zero completion blocks a new start for one cycle
  assign start   = ctrl_wr & d_in[0] & ~pend_q;
  assign last    = (cnt_q == CNT_W'(1));
  assign irq     = done_q & irq_en_q;

  // Shift-add multiply step
  assign mul_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod    = 32'(mul_sum);

  // Restoring divide step; borrow bit of diff decides restore
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvsr_q};
  assign ge      = ~diff[WIDTH];
  assign rem_nx  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    rd_data = '0;
    case (addr)
      3'd0: rd_data = 16'(a_q);
      3'd1: rd_data = 16'(b_q);
      3'd2: rd_data = {11'b0, irq_en_q, mode_q,
                       div0_q, busy, done_q};
      3'd3: rd_data = res_lo_q;
      3'd4: rd_data = res_hi_q;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!d_in[1])
            state_d = MUL;
          else if (b_q != '0)
            state_d = DIV;
          else
            state_d = IDLE;
        end
      end
      MUL: if (last) state_d = IDLE;
      DIV: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      d_out    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      pend_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
    end else begin
      state_q <= state_d;
      d_out   <= (cs && rd) ? rd_data : '0;

      if (wr_en && addr == 3'd0)
        a_q <= d_in[WIDTH-1:0];
      if (wr_en && addr == 3'd1)
        b_q <= d_in[WIDTH-1:0];

      if (ctrl_wr) begin
        mode_q   <= d_in[1];
        irq_en_q <= d_in[2];
        if (d_in[0] || d_in[3]) begin
          done_q <= 1'b0;
          div0_q <= 1'b0;
        end
      end

      if (start) begin
        cnt_q    <= CNT_W'(WIDTH);
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a_q};
        mplier_q <= b_q;
        rem_q    <= '0;
        quo_q    <= a_q;
        dvsr_q   <= b_q;
        pend_q   <= d_in[1] && (b_q == '0);
      end

      // Divide by zero: finish one cycle after start, A kept in quo_q
      if (pend_q) begin
        pend_q   <= 1'b0;
        done_q   <= 1'b1;
        div0_q   <= 1'b1;
        res_lo_q <= 16'({WIDTH{1'b1}});
        res_hi_q <= 16'(quo_q);
      end

      case (state_q)
        MUL: begin
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (last) begin
            res_lo_q <= prod[15:0];
            res_hi_q <= prod[31:16];
            done_q   <= 1'b1;
          end
        end
        DIV: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last) begin
            res_lo_q <= 16'(quo_nx);
            res_hi_q <= 16'(rem_nx);
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_muldiv.sv
// Directed bench for peripheral_muldiv (WIDTH=16).
// Bus tasks, status polling, one shared check task.
module tb_peripheral_muldiv;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [2:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        irq;

  int n_chk;
  int n_err;

  peripheral_muldiv #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cs(cs),
    .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a,
                        input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic rd_reg(input logic [2:0] a,
                        output logic [15:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    d = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  // Reads status each cycle until done; counts reads and busy samples
  task automatic wait_done(output int nbusy, output int nrd);
    logic [15:0] s;
    nbusy = 0;
    nrd = 0;
    s = '0;
    for (int i = 0; i < 40; i++) begin
      rd_reg(3'd2, s);
      nrd++;
      if (s[0]) break;
      if (s[1]) nbusy++;
    end
    chk("done_seen", {15'b0, s[0]}, 16'd1);
  endtask

  logic [15:0] v;
  int nb;
  int nr;

  initial begin
    n_chk = 0; n_err = 0;
    d_in = '0; cs = 1'b0; addr = '0;
    rd = 1'b0; wr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", d_out, 16'h0);
    chk("rst_irq", {15'b0, irq}, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_reg(3'd2, v); chk("rst_status", v, 16'h0);

    // 1: 5*2
    wr_reg(3'd0, 16'd5);
    wr_reg(3'd1, 16'd2);
    wr_reg(3'd2, 16'h0001);
    wait_done(nb, nr);
    chk("t1_busy_cycles", 16'(nb), 16'd16);
    chk("t1_done_lat", 16'(nr), 16'd17);
    rd_reg(3'd3, v); chk("t1_lo", v, 16'h000A);
    rd_reg(3'd4, v); chk("t1_hi", v, 16'h0000);
    rd_reg(3'd2, v); chk("t1_status", v, 16'h0001);

    // 2: max*max
    wr_reg(3'd0, 16'hFFFF);
    wr_reg(3'd1, 16'hFFFF);
    wr_reg(3'd2, 16'h0001);
    wait_done(nb, nr);
    chk("t2_busy_cycles", 16'(nb), 16'd16);
    rd_reg(3'd3, v); chk("t2_lo", v, 16'h0001);
    rd_reg(3'd4, v); chk("t2_hi", v, 16'hFFFE);

    // 3: 100/7 then 35/0
    wr_reg(3'd0, 16'd100);
    wr_reg(3'd1, 16'd7);
    wr_reg(3'd2, 16'h0003);
    wait_done(nb, nr);
    chk("t3_busy_cycles", 16'(nb), 16'd16);
    rd_reg(3'd3, v); chk("t3_quo", v, 16'd14);
    rd_reg(3'd4, v); chk("t3_rem", v, 16'd2);
    rd_reg(3'd2, v); chk("t3_status", v, 16'h0009);
    wr_reg(3'd0, 16'd35);
    wr_reg(3'd1, 16'd0);
    wr_reg(3'd2, 16'h0003);
    wait_done(nb, nr);
    chk("t3z_busy", 16'(nb), 16'd0);
    chk("t3z_lat", 16'(nr), 16'd2);
    rd_reg(3'd2, v); chk("t3z_status", v, 16'h000D);
    rd_reg(3'd3, v); chk("t3z_quo", v, 16'hFFFF);
    rd_reg(3'd4, v); chk("t3z_rem", v, 16'd35);

    // 4: writes ignored while busy
    wr_reg(3'd0, 16'd5);
    wr_reg(3'd1, 16'd2);
    wr_reg(3'd2, 16'h0001);
    wr_reg(3'd0, 16'd9);
    wr_reg(3'd2, 16'h0001);
    wait_done(nb, nr);
    chk("t4_busy_cycles", 16'(nb), 16'd14);
    chk("t4_done_lat", 16'(nr), 16'd15);
    rd_reg(3'd0, v); chk("t4_a_kept", v, 16'd5);
    rd_reg(3'd3, v); chk("t4_lo", v, 16'h000A);
    rd_reg(3'd2, v); chk("t4_no_restart", v, 16'h0001);

    // 5: interrupt
    wr_reg(3'd0, 16'd3);
    wr_reg(3'd1, 16'd4);
    wr_reg(3'd2, 16'h0005);
    chk("t5_irq_low", {15'b0, irq}, 16'd0);
    wait_done(nb, nr);
    chk("t5_irq_high", {15'b0, irq}, 16'd1);
    rd_reg(3'd3, v); chk("t5_lo", v, 16'd12);
    wr_reg(3'd2, 16'h000C);
    chk("t5_irq_clr", {15'b0, irq}, 16'd0);
    rd_reg(3'd2, v); chk("t5_status", v, 16'h0010);

    // Unmapped address and read/write collision
    wr_reg(3'd5, 16'h1234);
    rd_reg(3'd5, v); chk("unmapped", v, 16'h0);
    cs = 1'b1; rd = 1'b1; wr = 1'b1;
    addr = 3'd0; d_in = 16'h00AB;
    @(posedge clk); #1;
    chk("rw_old", d_out, 16'd3);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    rd_reg(3'd0, v); chk("rw_new", v, 16'h00AB);

    // 6: reset mid-divide
    wr_reg(3'd0, 16'd100);
    wr_reg(3'd1, 16'd7);
    wr_reg(3'd2, 16'h0007);
    cs = 1'b1; rd = 1'b1; addr = 3'd2;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy_pre", d_out, 16'h001A);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_dout", d_out, 16'h0);
    chk("t6_rst_irq", {15'b0, irq}, 16'h0);
    cs = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_reg(3'd2, v); chk("t6_status", v, 16'h0);
    rd_reg(3'd3, v); chk("t6_lo", v, 16'h0);
    rd_reg(3'd4, v); chk("t6_hi", v, 16'h0);
    rd_reg(3'd0, v); chk("t6_a", v, 16'h0);
    wr_reg(3'd0, 16'd5);
    wr_reg(3'd1, 16'd2);
    wr_reg(3'd2, 16'h0001);
    wait_done(nb, nr);
    chk("t6_busy_cycles", 16'(nb), 16'd16);
    rd_reg(3'd3, v); chk("t6_lo_after", v, 16'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
